// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag layout.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_SHL  = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_V    = 2;
  localparam int unsigned FLAG_C    = 3;
  localparam int unsigned NUM_FLAGS = 4;

  // Bit order matches the flag register's packed input: {C, V, N, Z}.
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  function automatic flags_t make_flags(input logic n, input logic v,
                                        input logic c, input logic z);
    flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier datapath, one partial product per step; sequenced by alu_seq.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product_c,
  output logic                 last_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [PW-1:0]    acc_q,    acc_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Multiplicand walks left while the multiplier walks right, so bit 0 always selects the add.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = PW'(a);
      mplier_d = b;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Next accumulator value is exposed so the top can register the final product on the last step.
  assign product_c = acc_d;
  assign last_c    = step && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake; drives result, NVCZ flags and the flag write-enable.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             flag_we
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  state_e           state_q,  state_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q,  flags_d;

  logic             mul_load_c;
  logic             mul_step_c;
  logic [PW-1:0]    product_c;
  logic             mul_last_c;
  logic             mul_hi_c;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_carry_c;
  logic             alu_ovf_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load_c),
    .step      (mul_step_c),
    .a         (a),
    .b         (b),
    .product_c (product_c),
    .last_c    (mul_last_c)
  );

  // Single-cycle ops; SUB reuses the adder as a + ~b + 1 so carry means "no borrow".
  always_comb begin
    b_eff_c     = (op == OP_SUB) ? ~b : b;
    sum_c       = {1'b0, a} + {1'b0, b_eff_c} + (WIDTH+1)'(op == OP_SUB);
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_SUB: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (a[MSB] == b_eff_c[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      OP_AND:  alu_res_c = a & b;
      OP_OR:   alu_res_c = a | b;
      OP_XOR:  alu_res_c = a ^ b;
      OP_NAND: alu_res_c = ~(a & b);
      OP_SHL: begin
        alu_res_c   = {a[WIDTH-2:0], 1'b0};
        alu_carry_c = a[MSB];
      end
      OP_MUL: ;
      default: ;
    endcase
  end

  assign mul_hi_c = |product_c[PW-1:WIDTH];

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    mul_load_c = 1'b0;
    mul_step_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_load_c = 1'b1;
            state_d    = S_MUL;
          end else begin
            result_d = alu_res_c;
            flags_d  = make_flags(alu_res_c[MSB], alu_ovf_c, alu_carry_c, alu_res_c == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        mul_step_c = 1'b1;
        if (mul_last_c) begin
          result_d = product_c[WIDTH-1:0];
          flags_d  = make_flags(product_c[MSB], mul_hi_c, mul_hi_c,
                                product_c[WIDTH-1:0] == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign flag_we  = done_q;
  assign result   = result_q;
  assign negative = flags_q.n;
  assign overflow = flags_q.v;
  assign carry    = flags_q.c;
  assign zero     = flags_q.z;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         negative;
  logic         overflow;
  logic         carry;
  logic         zero;
  logic         flag_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .negative (negative),
    .overflow (overflow),
    .carry    (carry),
    .zero     (zero),
    .flag_we  (flag_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {N, V, C, Z, result} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    int unsigned ux = x;
    int unsigned uy = y;
    int unsigned r  = 0;
    int          sx = $signed(x);
    int          sy = $signed(y);
    int          sr;
    logic        c  = 1'b0;
    logic        v  = 1'b0;
    logic [15:0] res;
    case (o)
      3'd0: begin r = ux + uy; c = (r > 32'hFFFF); sr = sx + sy; v = (sr > 32767) || (sr < -32768); end
      3'd1: begin r = ux - uy; c = (ux >= uy);     sr = sx - sy; v = (sr > 32767) || (sr < -32768); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: r = ~(ux & uy);
      3'd6: begin r = ux << 1; c = x[15]; end
      default: begin r = ux * uy; c = ((r >> 16) != 0); v = c; end
    endcase
    res = r[15:0];
    return {res[15], v, c, (res == 16'h0), res};
  endfunction

  // Launch one op, optionally pulse a stray ADD start at cycle inj, and check timing and outputs.
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input int inj);
    logic [19:0] e;
    int cyc     = 0;
    int busy_n  = 0;
    int exp_lat = (o == 3'd7) ? W + 1 : 1;
    e = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cyc++;
      start = (inj != 0) && (cyc == inj);
      if (start) begin
        op = 3'd0; a = W'($urandom); b = W'($urandom);
      end
      if (done || cyc >= 40) break;
      if (busy) busy_n++;
    end
    check($sformatf("latency op%0d", o), cyc, exp_lat);
    check($sformatf("busy_cycles op%0d", o), busy_n, (o == 3'd7) ? W : 0);
    check($sformatf("result op%0d a=%h b=%h", o, x, y), result, e[15:0]);
    check($sformatf("nvcz op%0d a=%h b=%h", o, x, y), {negative, overflow, carry, zero}, e[19:16]);
    check("done_cycle we/busy", {flag_we, busy}, 2'b10);
    @(negedge clk);
    check("post_done done/we", {done, flag_we}, 2'b00);
    check("result_hold", {negative, overflow, carry, zero, result}, e);
  endtask

  initial begin
    int seen;
    logic prev_we;
    logic [19:0] e;
    rst_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", {busy, done, flag_we, negative, overflow, carry, zero, result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 16'h7FFF, 16'h0001, 0);
    run_op(3'd1, 16'h0005, 16'h0005, 0);
    run_op(3'd1, 16'h0000, 16'h0001, 0);
    run_op(3'd7, 16'h0100, 16'h0100, 3);
    run_op(3'd6, 16'h8001, 16'h0000, 0);
    run_op(3'd5, 16'hFFFF, 16'hFFFF, 0);
    run_op(3'd7, 16'hFFFF, 16'hFFFF, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o = 3'($urandom_range(0, 7));
      logic [15:0] x = 16'($urandom);
      logic [15:0] y = 16'($urandom);
      if ($urandom_range(0, 4) == 0) x = (i % 2) ? 16'h8000 : 16'hFFFF;
      run_op(o, x, y, (o == 3'd7) ? $urandom_range(1, 12) : 0);
    end

    // Reset in the middle of a multiply: everything clears at once and no done ever appears.
    run_op(3'd0, 16'h1234, 16'h0001, 0);
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 16'h0003; b = 16'h0007;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_mul_reset", {busy, done, flag_we, negative, overflow, carry, zero, result}, 0);
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done || flag_we) seen++;
    end
    check("no_done_after_reset", seen, 0);
    run_op(3'd0, 16'h0002, 16'h0003, 0);

    // start held high with ADD: done on every other cycle, never on two in a row.
    e = model(3'd0, 16'h1234, 16'h1111);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 16'h1234; b = 16'h1111;
    prev_we = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("b2b_done[%0d]", i), done, 32'(i % 2));
      check($sformatf("b2b_we_pair[%0d]", i), prev_we & flag_we, 0);
      if (done) check($sformatf("b2b_result[%0d]", i), result, e[15:0]);
      prev_we = flag_we;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle ALU for the 16-bit CPU datapath, directly upstream of the flag register.
- Computes a result and the four condition flags (negative, overflow, carry, zero), then pulses a flag write-enable that drives the flag register's c14 input.
- Single-cycle ops complete in one cycle. MUL is a sequential shift-add taking WIDTH cycles.
- Controller interface is a start/busy/done handshake.

Parameters:
- WIDTH, 16, datapath width in bits; must be >= 4.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled on posedge only while state is IDLE.
- op  input  3  opcode, captured with start.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high while an operation is in progress; start is ignored while high.
- done  output  1  one-cycle pulse; result and flags are valid in this cycle.
- result  output  WIDTH  registered result; holds its value until the next done.
- negative  output  1  result[WIDTH-1]; registered.
- overflow  output  1  signed overflow flag; registered.
- carry  output  1  carry flag; registered.
- zero  output  1  result == 0; registered.
- flag_we  output  1  equals done; connects to the flag register c14 input.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE and clears busy, done, flag_we, result, all four flags and the internal accumulator, counter and operand registers to 0 immediately. Reset mid-MUL abandons the operation and produces no done.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 SHL (a shifted left by 1), 7 MUL (unsigned; low WIDTH bits form the result).
- States:
  - IDLE: start=1 with op!=MUL computes in the same cycle and registers result and flags. The FSM moves to DONE, so done is high in the cycle after the start edge (latency 1).
  - IDLE with start=1 and op==MUL: operands are captured, the accumulator and counter are cleared, and the FSM moves to MUL. busy is high throughout MUL.
  - MUL: one shift-add step per cycle, WIDTH steps, counter 0..WIDTH-1. Exits to DONE after step WIDTH-1. Latency from the start edge to done is WIDTH+1 cycles.
  - DONE: done=flag_we=1 for exactly one cycle, busy=0, then IDLE unconditionally. start asserted in DONE is ignored; the controller must reassert start in IDLE.
- Flags per op:
  - ADD: carry = unsigned carry-out of a+b; overflow = a and b have the same sign and the result sign differs.
  - SUB: computed as a+~b+1; carry = carry-out (1 means no borrow, i.e. a >= b unsigned); overflow = a and b have different signs and the result sign differs from a.
  - AND, OR, XOR, NAND: carry=0, overflow=0.
  - SHL: carry = a[WIDTH-1]; overflow=0.
  - MUL: carry = OR of the high WIDTH bits of the 2*WIDTH-bit product; overflow = carry.
  - All ops: negative = result MSB; zero = (result == 0).
- Flag capture timing: flags and flag_we are posedge registers stable for the whole done cycle, so the flag register captures them on the negedge within that cycle.
- Outside the done cycle flag_we=0 and the flag outputs hold their last values.
- start asserted while busy: ignored, with no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH with no saturation.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_ADD..OP_MUL, 3-bit;
  - FSM state encoding: S_IDLE, S_MUL, S_DONE;
  - flag bit-index constants FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3, matching the flag register's packed output.
- One natural sub-module: alu_mul_seq, the shift-add multiplier datapath (accumulator, shifting multiplier, step counter), driven by the top FSM.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> done exactly 1 cycle after start; result=0x8000, N=1 V=1 C=0 Z=0, flag_we=1 for one cycle.
- SUB a=0x0005 b=0x0005 -> result=0x0000, Z=1 C=1 N=0 V=0. SUB a=0x0000 b=0x0001 -> result=0xFFFF, C=0 N=1 V=0.
- MUL a=0x0100 b=0x0100 -> busy high for 16 cycles, done 17 cycles after start; result=0x0000, Z=1 C=1 V=1. A start with op=ADD pulsed mid-MUL is ignored.
- SHL a=0x8001 -> result=0x0002, C=1 V=0 N=0. NAND a=0xFFFF b=0xFFFF -> result=0x0000, Z=1 C=0 V=0.
- MUL a=0x0003 b=0x0007 with rst_n pulled low at cycle 5 of MUL -> all outputs 0 immediately and no done. After release, ADD a=0x0002 b=0x0003 -> result=0x0005 after 1 cycle.
- Back-to-back: start held high continuously with ADD -> done every 2 cycles (IDLE, DONE alternating); flag_we never high for 2 consecutive cycles.
